// File: rtl/pbit_pkg.sv
// Shared constants and types for the p-bit bank: fixed-point defaults, LFSR taps, FSM encoding.
package pbit_pkg;

   localparam int unsigned DEF_INT_SIZE   = 8;
   localparam int unsigned DEF_FLOAT_SIZE = 24;
   localparam logic [31:0] FIX_ONE        = 32'h01_000000;
   localparam logic [15:0] LFSR_MASK      = 16'hB400;

   typedef enum logic [1:0] {
      IDLE,
      ACT,
      CMP
   } pbit_fsm_t;

endpackage

// File: rtl/pbit_lfsr.sv
// 16-bit Galois LFSR, free-running whenever reset is low; a zero seed is forced to 1.
module pbit_lfsr
   import pbit_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        CLK,
   input  logic        RST,
   output logic [15:0] q
);

   localparam logic [15:0] SEED_NZ = (SEED == '0) ? 16'h0001 : SEED;

   always_ff @(posedge CLK) begin
      if (RST) begin
         q <= SEED_NZ;
      end else if (q[0]) begin
         q <= (q >> 1) ^ LFSR_MASK;
      end else begin
         q <= q >> 1;
      end
   end

endmodule

// File: rtl/pbit_bank.sv
// N-channel p-bit bank: hard-tanh activation, LFSR threshold compare, one update per 3 cycles.
// Optional macro PBIT_BETA_EN adds a beta_shift port that scales z (with saturation) at accept.
module pbit_bank
   import pbit_pkg::*;
#(
   parameter int unsigned N_PBITS    = 8,
   parameter int unsigned INT_SIZE   = DEF_INT_SIZE,
   parameter int unsigned FLOAT_SIZE = DEF_FLOAT_SIZE,
   parameter int unsigned RNG_WIDTH  = 16,
   parameter logic [15:0] SEED       = 16'hACE1,
   localparam int unsigned IDX_W     = (N_PBITS > 1) ? $clog2(N_PBITS) : 1,
   localparam int unsigned ZW        = INT_SIZE + FLOAT_SIZE
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               upd_valid,
   output logic               upd_ready,
   input  logic [IDX_W-1:0]   upd_idx,
   input  logic [ZW-1:0]      upd_z,
`ifdef PBIT_BETA_EN
   input  logic [2:0]         beta_shift,
`endif
   output logic               done_valid,
   output logic [IDX_W-1:0]   done_idx,
   output logic               done_val,
   output logic [N_PBITS-1:0] pbit_state
);

   localparam logic signed [ZW-1:0] LSB_S   = {{(ZW-1){1'b0}}, 1'b1};
   localparam logic signed [ZW-1:0] ONE_S   = LSB_S << FLOAT_SIZE;
   localparam logic signed [ZW-1:0] POS_LIM = ONE_S - LSB_S;
   localparam logic signed [ZW-1:0] NEG_LIM = -ONE_S;

   pbit_fsm_t                state_q, state_d;
   logic [IDX_W-1:0]         idx_q;
   logic signed [ZW-1:0]     z_q;
   logic signed [ZW-1:0]     z_in;
   logic signed [ZW-1:0]     t;
   logic [RNG_WIDTH-1:0]     thr_d, thr_q;
   logic [15:0]              lfsr_q;
   logic                     val;

   pbit_lfsr #(.SEED(SEED)) u_lfsr (
      .CLK (CLK),
      .RST (RST),
      .q   (lfsr_q)
   );

`ifdef PBIT_BETA_EN
   localparam logic signed [ZW+7:0] Z_MAX_W = {9'b0, {(ZW-1){1'b1}}};
   localparam logic signed [ZW+7:0] Z_MIN_W = {{9{1'b1}}, {(ZW-1){1'b0}}};
   logic signed [ZW+7:0] z_ext, z_shl;

   // Shift in 8 guard bits so overflow is detected before truncating back to ZW.
   always_comb begin
      z_ext = {{8{upd_z[ZW-1]}}, upd_z};
      z_shl = z_ext <<< beta_shift;
      if (z_shl > Z_MAX_W) begin
         z_in = Z_MAX_W[ZW-1:0];
      end else if (z_shl < Z_MIN_W) begin
         z_in = Z_MIN_W[ZW-1:0];
      end else begin
         z_in = z_shl[ZW-1:0];
      end
   end
`else
   always_comb begin
      z_in = upd_z;
   end
`endif

   // Clamp first so t + ONE stays non-negative and below 2*ONE; thr is p's top RNG_WIDTH bits.
   always_comb begin
      if (z_q > POS_LIM) begin
         t = POS_LIM;
      end else if (z_q < NEG_LIM) begin
         t = NEG_LIM;
      end else begin
         t = z_q;
      end
      thr_d = RNG_WIDTH'((t + ONE_S) >> (FLOAT_SIZE + 1 - RNG_WIDTH));
      val   = (lfsr_q <= thr_q);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      upd_ready = 1'b0;
      case (state_q)
         IDLE: begin
            upd_ready = 1'b1;
            if (upd_valid) begin
               state_d = ACT;
            end
         end
         ACT:     state_d = CMP;
         CMP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         idx_q      <= '0;
         z_q        <= '0;
         thr_q      <= '0;
         done_valid <= 1'b0;
         done_idx   <= '0;
         done_val   <= 1'b0;
         pbit_state <= '0;
      end else begin
         done_valid <= 1'b0;
         case (state_q)
            IDLE: begin
               if (upd_valid) begin
                  idx_q <= upd_idx;
                  z_q   <= z_in;
               end
            end
            ACT: thr_q <= thr_d;
            CMP: begin
               done_valid <= 1'b1;
               done_idx   <= idx_q;
               done_val   <= val;
               if (32'(idx_q) < N_PBITS) begin
                  pbit_state[idx_q] <= val;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
